// File: rtl/dffrs_pipe.sv
// Forceable WIDTH x DEPTH register pipeline with valid/ready handshake and bubble collapse.
// Latency: DEPTH cycles from D acceptance to Q_VLD when Q_RDY stays high; 1 item/cycle.
// Backpressure: D_RDY is combinational from Q_RDY through the advance chain; empty stages still fill.
// Optional scan chain over all data bits when DFFRS_PIPE_SCAN_EN is defined.
module dffrs_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3
) (
  input  logic             CK,
  input  logic             RST,
  input  logic [WIDTH-1:0] D,
  input  logic             D_VLD,
  output logic             D_RDY,
  input  logic             SET,
  input  logic             CLR,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QN,
  output logic             Q_VLD,
  input  logic             Q_RDY
`ifdef DFFRS_PIPE_SCAN_EN
  ,
  input  logic             SE,
  input  logic             SI,
  output logic             SO
`endif
);

  logic [WIDTH-1:0] data     [DEPTH];
  logic [WIDTH-1:0] data_nxt [DEPTH];
  logic [WIDTH-1:0] up_dat   [DEPTH];
  logic [DEPTH-1:0] vld, vld_nxt;
  logic [DEPTH-1:0] cfl, cfl_nxt;
  logic [DEPTH-1:0] up_cfl;
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] load;
  logic             scan;

`ifdef DFFRS_PIPE_SCAN_EN
  logic [DEPTH-1:0] scan_in;

  assign scan = SE;
  assign SO   = data[DEPTH-1][WIDTH-1];

  // Shift-chain source per stage: SI feeds stage 0, each later stage takes the MSB of the one before.
  always_comb begin
    scan_in    = '0;
    scan_in[0] = SI;
    for (int i = 1; i < DEPTH; i++) begin
      scan_in[i] = data[i-1][WIDTH-1];
    end
  end
`else
  assign scan = 1'b0;
`endif

  // Advance chain from the output back to stage 0; frozen entirely while scanning.
  always_comb begin
    adv          = '0;
    adv[DEPTH-1] = vld[DEPTH-1] & Q_RDY & ~scan;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      adv[i] = vld[i] & (~vld[i+1] | adv[i+1]) & ~scan;
    end
  end

  assign D_RDY = (~vld[0] | adv[0]) & ~scan;

  // Upstream source of each stage: D (with a clean conflict flag) for stage 0, the previous stage otherwise.
  always_comb begin
    up_cfl    = '0;
    load      = '0;
    up_dat[0] = D;
    load[0]   = D_VLD & D_RDY;
    for (int i = 1; i < DEPTH; i++) begin
      up_dat[i] = data[i-1];
      up_cfl[i] = cfl[i-1];
      load[i]   = adv[i-1];
    end
  end

  // Next state per stage: load/empty/hold for valid, then force applied on top of whatever was loaded.
  always_comb begin
    vld_nxt = '0;
    cfl_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      vld_nxt[i]  = load[i] ? 1'b1 : (adv[i] ? 1'b0 : vld[i]);
      data_nxt[i] = load[i] ? up_dat[i] : data[i];
      cfl_nxt[i]  = load[i] ? up_cfl[i] : cfl[i];
      if (SET && CLR) begin
        data_nxt[i] = '0;
        cfl_nxt[i]  = 1'b1;
      end else if (SET) begin
        data_nxt[i] = '1;
        cfl_nxt[i]  = 1'b0;
      end else if (CLR) begin
        data_nxt[i] = '0;
        cfl_nxt[i]  = 1'b0;
      end
`ifdef DFFRS_PIPE_SCAN_EN
      // Scan ignores force and holds flags; only the data bits shift.
      if (SE) begin
        data_nxt[i] = (data[i] << 1) | WIDTH'(scan_in[i]);
        cfl_nxt[i]  = cfl[i];
        vld_nxt[i]  = vld[i];
      end
`endif
    end
  end

  // Stage registers; reset wins over force, scan and handshake.
  always_ff @(posedge CK) begin
    if (RST) begin
      vld <= '0;
      cfl <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data[i] <= '0;
      end
    end else begin
      vld <= vld_nxt;
      cfl <= cfl_nxt;
      for (int i = 0; i < DEPTH; i++) begin
        data[i] <= data_nxt[i];
      end
    end
  end

  assign Q     = data[DEPTH-1];
  assign Q_VLD = vld[DEPTH-1];
  // A conflicted output stage reads as zero on both rails.
  assign QN    = ~Q & {WIDTH{~cfl[DEPTH-1]}};

endmodule

// File: tb/tb_dffrs_pipe.sv
// Directed bench for dffrs_pipe at WIDTH=8, DEPTH=3 (scan macro undefined).
// Each vector row is driven at the falling edge and outputs are sampled before the next rising edge.
// Extra hand sequences cover reset during traffic and first-item latency.
module tb_dffrs_pipe;

  logic       CK = 1'b0;
  logic       RST, D_VLD, D_RDY, SET, CLR, Q_VLD, Q_RDY;
  logic [7:0] D, Q, QN;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [7:0] d;
    logic       dv, set, clr, qr, chk_q;
    logic [7:0] q, qn;
    logic       qv, dr;
  } vec_t;

  vec_t vecs[$];

  dffrs_pipe #(.WIDTH(8), .DEPTH(3)) dut (
    .CK(CK), .RST(RST), .D(D), .D_VLD(D_VLD), .D_RDY(D_RDY),
    .SET(SET), .CLR(CLR), .Q(Q), .QN(QN), .Q_VLD(Q_VLD), .Q_RDY(Q_RDY)
  );

  always #5 CK = ~CK;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [7:0] d, input logic dv, input logic set, input logic clr,
                     input logic qr, input logic chk_q, input logic [7:0] q, input logic [7:0] qn,
                     input logic qv, input logic dr);
    vec_t v;
    v.d = d; v.dv = dv; v.set = set; v.clr = clr; v.qr = qr; v.chk_q = chk_q;
    v.q = q; v.qn = qn; v.qv = qv; v.dr = dr;
    vecs.push_back(v);
  endtask

  initial begin
    int cnt;
    //     d    dv set clr qr chk  q     qn    qv dr
    add(8'h00, 0, 0, 0, 1, 1, 8'h00, 8'hFF, 0, 1); // reset state
    add(8'h11, 1, 0, 0, 1, 1, 8'h00, 8'hFF, 0, 1); // stream in
    add(8'h22, 1, 0, 0, 1, 1, 8'h00, 8'hFF, 0, 1);
    add(8'h33, 1, 0, 0, 1, 1, 8'h00, 8'hFF, 0, 1);
    add(8'h00, 0, 0, 0, 1, 1, 8'h11, 8'hEE, 1, 1); // 3 cycles later
    add(8'h00, 0, 0, 0, 1, 1, 8'h22, 8'hDD, 1, 1);
    add(8'h00, 0, 0, 0, 1, 1, 8'h33, 8'hCC, 1, 1);
    add(8'h00, 0, 0, 0, 1, 0, 8'h00, 8'h00, 0, 1);
    add(8'h11, 1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 1); // backpressure fill
    add(8'h22, 1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 1);
    add(8'h33, 1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 1);
    add(8'h44, 1, 0, 0, 0, 1, 8'h11, 8'hEE, 1, 0); // full, 4th refused
    add(8'h44, 1, 0, 0, 0, 1, 8'h11, 8'hEE, 1, 0);
    add(8'h44, 1, 0, 0, 1, 1, 8'h11, 8'hEE, 1, 1); // release
    add(8'h00, 0, 0, 0, 1, 1, 8'h22, 8'hDD, 1, 1);
    add(8'h00, 0, 0, 0, 1, 1, 8'h33, 8'hCC, 1, 1);
    add(8'h00, 0, 0, 0, 1, 1, 8'h44, 8'hBB, 1, 1);
    add(8'h00, 0, 0, 0, 1, 0, 8'h00, 8'h00, 0, 1);
    add(8'hA1, 1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 1); // fill for force
    add(8'hB2, 1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 1);
    add(8'hC3, 1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 1);
    add(8'h00, 0, 1, 0, 0, 1, 8'hA1, 8'h5E, 1, 0); // SET
    add(8'h00, 0, 0, 0, 0, 1, 8'hFF, 8'h00, 1, 0);
    add(8'h00, 0, 0, 1, 0, 1, 8'hFF, 8'h00, 1, 0); // CLR
    add(8'h00, 0, 0, 0, 0, 1, 8'h00, 8'hFF, 1, 0);
    add(8'h00, 0, 1, 1, 0, 1, 8'h00, 8'hFF, 1, 0); // SET+CLR
    add(8'h00, 0, 0, 0, 0, 1, 8'h00, 8'h00, 1, 0);
    add(8'h5A, 1, 0, 0, 1, 1, 8'h00, 8'h00, 1, 1); // new item behind conflicts
    add(8'h00, 0, 0, 0, 1, 1, 8'h00, 8'h00, 1, 1);
    add(8'h00, 0, 0, 0, 1, 1, 8'h00, 8'h00, 1, 1);
    add(8'h00, 0, 0, 0, 1, 1, 8'h5A, 8'hA5, 1, 1);
    add(8'h00, 0, 0, 0, 1, 0, 8'h00, 8'h00, 0, 1);
    add(8'h77, 1, 1, 0, 1, 0, 8'h00, 8'h00, 0, 1); // SET on loaded value
    add(8'h12, 1, 0, 0, 1, 0, 8'h00, 8'h00, 0, 1);
    add(8'h00, 0, 0, 0, 1, 0, 8'h00, 8'h00, 0, 1);
    add(8'h00, 0, 0, 0, 1, 1, 8'hFF, 8'h00, 1, 1);
    add(8'h00, 0, 0, 0, 1, 1, 8'h12, 8'hED, 1, 1);
    add(8'h00, 0, 0, 0, 1, 0, 8'h00, 8'h00, 0, 1);

    RST = 1'b1; D = '0; D_VLD = 1'b0; SET = 1'b0; CLR = 1'b0; Q_RDY = 1'b1;
    @(negedge CK);
    RST = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      if (i != 0) @(negedge CK);
      D = vecs[i].d; D_VLD = vecs[i].dv; SET = vecs[i].set; CLR = vecs[i].clr; Q_RDY = vecs[i].qr;
      #2;
      if (vecs[i].chk_q) begin
        check($sformatf("v%0d Q", i), Q, vecs[i].q);
        check($sformatf("v%0d QN", i), QN, vecs[i].qn);
      end
      check($sformatf("v%0d Q_VLD", i), {7'd0, Q_VLD}, {7'd0, vecs[i].qv});
      check($sformatf("v%0d D_RDY", i), {7'd0, D_RDY}, {7'd0, vecs[i].dr});
    end

    // Reset in the middle of traffic overrides SET and the handshake.
    @(negedge CK);
    D = 8'h99; D_VLD = 1'b1; SET = 1'b0; CLR = 1'b0; Q_RDY = 1'b0;
    @(negedge CK);
    @(negedge CK);
    RST = 1'b1; SET = 1'b1;
    @(negedge CK);
    RST = 1'b0; SET = 1'b0; D_VLD = 1'b0;
    #2;
    check("rst Q", Q, 8'h00);
    check("rst QN", QN, 8'hFF);
    check("rst Q_VLD", {7'd0, Q_VLD}, 8'd0);
    check("rst D_RDY", {7'd0, D_RDY}, 8'd1);

    // First-item latency: count rising edges from acceptance until Q_VLD.
    @(negedge CK);
    Q_RDY = 1'b1; D = 8'h3C; D_VLD = 1'b1;
    cnt = 0;
    do begin
      @(posedge CK);
      #1;
      D_VLD = 1'b0;
      cnt++;
    end while (!Q_VLD && cnt < 10);
    check("latency", 8'(cnt), 8'd3);
    check("latency Q", Q, 8'h3C);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
